// File: rtl/aes_pkg.sv
// Shared definitions for the Rijndael ShiftRows/InvShiftRows datapath.
// Holds the per-NB row shift offsets, the byte/row/column index helpers
// and the state-width constants used by aes_shift_rows_pipe and
// aes_shift_rows_perm.
package aes_pkg;

    localparam int BYTE_W     = 8;
    localparam int ROWS       = 4;
    localparam int WORD_W     = ROWS * BYTE_W;
    localparam int NB_DEFAULT = 4;

    // State width for the default four-column configuration (32*NB).
    localparam int STATE_W_DEFAULT = WORD_W * NB_DEFAULT;

    // State width for an arbitrary column count.
    function automatic int state_width(input int nb);
        return WORD_W * nb;
    endfunction

    // Row rotation amount. Rijndael uses 0,1,2,3 for 4 and 6 columns and
    // 0,1,3,4 for 8 columns; row 0 never moves.
    function automatic int shift_offset(input int nb, input int row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    // Column that feeds output byte (col,row). Forward rotates left by the
    // row offset, inverse rotates right by the same amount.
    function automatic int src_col(input int nb, input int col, input int row, input bit inv);
        int s;
        s = shift_offset(nb, row);
        if (inv) begin
            return (col - s + nb) % nb;
        end
        return (col + s) % nb;
    endfunction

    // MSB position of byte (col,row) in the packed state bus. Column 0
    // occupies the top word and row 0 is the top byte of each column.
    function automatic int byte_msb(input int nb, input int col, input int row);
        return state_width(nb) - 1 - col * WORD_W - row * BYTE_W;
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational ShiftRows/InvShiftRows byte permutation for an NB-column
// state. Every output byte is a fixed wire from one input byte, so the
// whole block is routing plus (optionally) a 2:1 mux per moved byte.
// Build option AES_SHIFTROWS_FWD_EN: when defined both directions exist
// and inv selects; otherwise only the inverse is built and inv is ignored.
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state,
    input  logic             inv,
    output logic [32*NB-1:0] permuted
);

    genvar gi, gj;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_col
            for (gj = 0; gj < ROWS; gj++) begin : g_row
                localparam int DST_MSB = byte_msb(NB, gi, gj);
                localparam int INV_MSB = byte_msb(NB, src_col(NB, gi, gj, 1'b1), gj);
`ifdef AES_SHIFTROWS_FWD_EN
                localparam int FWD_MSB = byte_msb(NB, src_col(NB, gi, gj, 1'b0), gj);
                // Per-byte direction select between the two rotations.
                assign permuted[DST_MSB -: BYTE_W] = inv ? state[INV_MSB -: BYTE_W]
                                                         : state[FWD_MSB -: BYTE_W];
`else
                // Decrypt-only build: fixed inverse rotation.
                assign permuted[DST_MSB -: BYTE_W] = state[INV_MSB -: BYTE_W];
`endif
            end
        end
    endgenerate

`ifndef AES_SHIFTROWS_FWD_EN
    // Direction input has no effect in the decrypt-only build.
    logic unused_inv;
    assign unused_inv = inv;
`endif

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Handshaked ShiftRows/InvShiftRows stage. The permuted state and its tag
// are written into a DEPTH-entry circular output buffer; the head entry is
// presented with valid/ready flow control. A push into a full buffer is
// allowed in the cycle the head is popped, so in_ready looks at out_ready.
// Build option AES_SHIFTROWS_FWD_EN enables the forward direction (see
// aes_shift_rows_perm); without it every transaction is InvShiftRows.
// Legal parameters: NB in {4,6,8}, DEPTH in 1..4.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_state,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      xfer_cnt
);

    localparam int STATE_W = state_width(NB);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [STATE_W-1:0] perm_state;

    logic [STATE_W-1:0] state_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic [15:0]      xfer_cnt_reg, xfer_cnt_next;

    logic push;
    logic pop;

    // Permutation sits ahead of the buffer write port so the buffer only
    // ever stores finished results; the mode is thereby fixed per entry.
    aes_shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .state    (in_state),
        .inv      (in_inv),
        .permuted (perm_state)
    );

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    // Held low during reset; a full buffer still accepts when the head leaves.
    assign in_ready  = !rst && ((count_reg < CNT_DEPTH) || pop);
    assign push      = in_valid && in_ready;

    assign out_state = state_mem[rd_ptr_reg];
    assign out_tag   = tag_mem[rd_ptr_reg];
    assign xfer_cnt  = xfer_cnt_reg;

    // Pointer, occupancy and transfer-counter next-state logic.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        xfer_cnt_next = xfer_cnt_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next   = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            xfer_cnt_next = xfer_cnt_reg + 16'd1;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Control registers; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            xfer_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            xfer_cnt_reg <= xfer_cnt_next;
        end
    end

    // Buffer storage. Entries are cleared on reset so out_state/out_tag
    // read as zero afterwards. When full with a simultaneous pop the write
    // lands in the slot being vacated, which is safe because the head is
    // consumed on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_mem[i] <= '0;
                tag_mem[i]   <= '0;
            end
        end else if (push) begin
            state_mem[wr_ptr_reg] <= perm_state;
            tag_mem[wr_ptr_reg]   <= in_tag;
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: a 4-column and an 8-column
// instance (DEPTH=2) driven on falling edges and sampled on falling edges.
// Expected states are hand-computed constants; the forward-mode
// expectations follow the AES_SHIFTROWS_FWD_EN build option.
module tb_aes_shift_rows_pipe;

    localparam logic [127:0] IN4  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FWD4 = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV4 = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [255:0] IN8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] FWD8 = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
    localparam logic [255:0] INV8 = 256'h001d161304011a1708051e1b0c09021f100d060314110a0718150e0b1c19120f;
`ifdef AES_SHIFTROWS_FWD_EN
    localparam logic [127:0] EXP_F4 = FWD4;
    localparam logic [255:0] EXP_F8 = FWD8;
`else
    localparam logic [127:0] EXP_F4 = INV4;
    localparam logic [255:0] EXP_F8 = INV8;
`endif

    logic clk = 1'b0;
    logic rst;

    logic         v4, r4, inv4, ov4, or4;
    logic [127:0] st4, os4;
    logic [3:0]   tg4, ot4;
    logic [15:0]  xc4;

    logic         v8, r8, inv8, ov8, or8;
    logic [255:0] st8, os8;
    logic [3:0]   tg8, ot8;
    logic [15:0]  xc8;

    int vectors     = 0;
    int miscompares = 0;
    int n_out;
    int stalls;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .TAG_W(4), .DEPTH(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (r4),
        .in_inv    (inv4),
        .in_state  (st4),
        .in_tag    (tg4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_state (os4),
        .out_tag   (ot4),
        .xfer_cnt  (xc4)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(4), .DEPTH(2)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (r8),
        .in_inv    (inv8),
        .in_state  (st8),
        .in_tag    (tg8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_state (os8),
        .out_tag   (ot8),
        .xfer_cnt  (xc8)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        v4 = 0; inv4 = 0; st4 = '0; tg4 = '0; or4 = 0;
        v8 = 0; inv8 = 0; st8 = '0; tg8 = '0; or8 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", r4, 0);
        check("rst_out_valid", ov4, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", r4, 1);
        check("post_rst_out_state", os4, 0);
        check("post_rst_out_tag", ot4, 0);
        check("post_rst_xfer_cnt", xc4, 0);
        check("post_rst_out_valid8", ov8, 0);

        // NB=4 forward request, visible one cycle after accept
        @(negedge clk);
        v4 = 1; st4 = IN4; inv4 = 0; tg4 = 4'h3;
        @(negedge clk);
        v4 = 0;
        check("fwd4_out_valid", ov4, 1);
        check("fwd4_out_state", os4, EXP_F4);
        check("fwd4_out_tag", ot4, 4'h3);
        or4 = 1;
        @(negedge clk);
        or4 = 0;
        check("fwd4_xfer_cnt", xc4, 1);
        check("fwd4_drained", ov4, 0);

        // NB=4 inverse request with tag 5
        v4 = 1; st4 = IN4; inv4 = 1; tg4 = 4'h5;
        @(negedge clk);
        v4 = 0;
        check("inv4_out_state", os4, INV4);
        check("inv4_out_tag", ot4, 4'h5);
        or4 = 1;
        @(negedge clk);
        or4 = 0;
        check("inv4_xfer_cnt", xc4, 2);

        // NB=8 forward, then inverse of the forward result
        v8 = 1; st8 = IN8; inv8 = 0; tg8 = 4'h1;
        @(negedge clk);
        v8 = 0;
        check("fwd8_out_state", os8, EXP_F8);
        check("fwd8_col0", os8[255:224], EXP_F8[255:224]);
        or8 = 1;
        v8 = 1; st8 = FWD8; inv8 = 1; tg8 = 4'h2;
        @(negedge clk);
        v8 = 0;
        check("rt8_out_state", os8, IN8);
        check("rt8_out_tag", ot8, 4'h2);
        @(negedge clk);
        or8 = 0;
        check("rt8_xfer_cnt", xc8, 2);

        // Backpressure: fill DEPTH=2, third waits for the first pop
        v4 = 1; st4 = IN4; inv4 = 1; tg4 = 4'h1;
        @(negedge clk);
        st4 = IN4; inv4 = 0; tg4 = 4'h2;
        check("bp_ready_one", r4, 1);
        @(negedge clk);
        st4 = FWD4; inv4 = 1; tg4 = 4'hc;
        check("bp_full_in_ready", r4, 0);
        check("bp_head_state", os4, INV4);
        @(negedge clk);
        check("bp_head_held_state", os4, INV4);
        check("bp_head_held_tag", ot4, 4'h1);
        or4 = 1;
        #1;
        check("bp_push_pop_ready", r4, 1);
        @(negedge clk);
        v4 = 0;
        check("bp_second_state", os4, EXP_F4);
        check("bp_second_tag", ot4, 4'h2);
        @(negedge clk);
        check("bp_third_state", os4, IN4);
        check("bp_third_tag", ot4, 4'hc);
        @(negedge clk);
        or4 = 0;
        check("bp_empty", ov4, 0);
        check("bp_xfer_cnt", xc4, 5);

        // Reset while full
        v4 = 1; st4 = IN4; inv4 = 1; tg4 = 4'h7;
        @(negedge clk);
        @(negedge clk);
        v4 = 0;
        check("full_before_rst", r4, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", ov4, 0);
        check("mid_rst_xfer_cnt", xc4, 0);
        check("mid_rst_in_ready", r4, 0);
        rst = 1'b0;
        or4 = 1;
        repeat (3) @(negedge clk);
        check("after_rst_no_stale", ov4, 0);
        check("after_rst_out_state", os4, 0);
        check("after_rst_xfer8", xc8, 0);

        // Streaming: 70000 transfers at one per cycle
        n_out = 0;
        stalls = 0;
        v4 = 1; st4 = IN4; inv4 = 1; tg4 = 4'h9;
        for (int i = 0; i <= 70000; i++) begin
            if (i == 70000) v4 = 0;
            if (ov4 && or4) n_out++;
            if (v4 && !r4) stalls++;
            @(negedge clk);
        end
        or4 = 0;
        check("stream_transfers", n_out, 70000);
        check("stream_stalls", stalls, 0);
        check("stream_xfer_wrap", xc4, 16'd4464);
        check("stream_drained", ov4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

Parametrised, handshaked ShiftRows/InvShiftRows stage for the Rijndael datapath. It supports 4-, 6- or 8-column states, selects forward or inverse per transaction, and carries a user tag. Results go through a registered output buffer with valid/ready flow control. It sits between the SubBytes/InvSubBytes and MixColumns/InvMixColumns stages of the round pipeline and replaces the fixed 128-bit combinational inverse permutation.

## Interface
Parameters:
- NB, 4 — state columns (32-bit words); legal values 4, 6, 8
- TAG_W, 4 — width of the sideband tag carried with each state
- DEPTH, 2 — output buffer entries; legal values 1..4

Ports (the state bus is packed with column 0 in the MSBs; within each column, row 0 is the MSB byte):
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept an input this cycle
- in_inv  in  1  1 = InvShiftRows, 0 = ShiftRows
- in_state  in  32*NB  input state
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  buffer head valid
- out_ready  in  1  downstream accepts the head
- out_state  out  32*NB  permuted state
- out_tag  out  TAG_W  tag of the head entry
- xfer_cnt  out  16  count of completed output transfers

## Operation
- Shift offsets by row (r = 0..3):
  - NB=4 or NB=6: 0, 1, 2, 3
  - NB=8: 0, 1, 3, 4
- Forward mode: out byte (col c, row r) = in byte (col (c+shift[r]) mod NB, row r).
- Inverse mode: out byte (col c, row r) = in byte (col (c−shift[r]+NB) mod NB, row r).
- Row 0 is never moved.
- Accept condition: in_valid && in_ready. On accept, the permuted state and the tag are written into the tail of the buffer.
- Buffer is a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy count (wrap at DEPTH).
  - Empty: out_valid = 0.
  - Full: in_ready = 0.
- in_ready = (count < DEPTH) || (out_valid && out_ready). A push into a full buffer is allowed in the same cycle as a pop.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count = 1, the popped entry is the old head and the new entry becomes the head next cycle.
- out_state, out_tag and out_valid are held stable while out_valid && !out_ready.
- xfer_cnt increments on each out_valid && out_ready and wraps from 0xFFFF to 0.
- Mode is latched per entry. Mixed forward and inverse transactions are permitted back-to-back.

## Timing
- Reset values: out_valid=0, in_ready=0 during rst, in_ready=1 on the first cycle after rst deasserts, out_state=0, out_tag=0, xfer_cnt=0, pointers=0, count=0.
- Latency: an input accepted in cycle N is visible on out_state/out_valid in cycle N+1 if the buffer was empty.
- Throughput: one state per cycle when out_ready is held high.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* to out_*.
- rst mid-operation: all buffered entries are discarded, and xfer_cnt clears on the next edge.

## Configuration
- AES_SHIFTROWS_FWD_EN
  - Defined: forward and inverse permutations are both built, and in_inv selects between them.
  - Undefined: only the inverse permutation is built, in_inv is ignored, and every transaction is InvShiftRows. This gives a smaller decrypt-only core.

## Structure
- Shared package aes_pkg holds:
  - the per-NB shift-offset constant function
  - byte/row/column index helpers
  - the state-width localparam (32*NB)
- One sub-module: aes_shift_rows_perm. It is purely combinational, takes parameter NB plus inputs state and inv, and produces the permuted state. The top level instantiates it once, ahead of the buffer write port.

## Test plan
- Forward, NB=4: input bytes 00..0f column-major, in_inv=0 → out 00050a0f 04090e03 080d0207 0c01060b in cycle N+1; xfer_cnt=1 after the pop.
- Inverse, NB=4: same input, in_inv=1 → out 000d0a07 04010e0b 0805020f 0c090603; tag 0x5 returned unchanged.
- NB=8, forward, input bytes 00..1f: out column 0 = 00 05 0e 13 (offsets 1, 3, 4). An inverse pass of that result restores the input.
- Backpressure, DEPTH=2: hold out_ready=0 and push 3 states → in_ready drops after 2 accepts. Raising out_ready drains the states in order with matching tags, and the third is accepted in the same cycle as the first pop.
- Streaming: continuous valid/ready for 70000 transfers → one output per cycle; xfer_cnt wraps to 70000−65536=4464.
- Reset while full → next cycle out_valid=0, count=0, xfer_cnt=0; no stale entry is ever presented.
